// File: rtl/conv_pkg.sv
// Shared widths and byte-lane selection for the 32-to-8 converter.
package conv_pkg;
  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [IDX_W-1:0]  idx_t;

  function automatic byte_t byte_sel(
    input word_t word,
    input idx_t  idx,
    input logic  msb_first
  );
    idx_t k;
    k = msb_first ? idx_t'(BYTES_PER_WORD-1) - idx : idx;
    return word[k*BYTE_W +: BYTE_W];
  endfunction
endpackage

// File: rtl/word_skid.sv
// One-entry pending word buffer sitting in front of the serializer slot.
module word_skid
  import conv_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              slot_free,
  output logic              acc,
  output logic [WORD_W-1:0] pend_word,
  output logic              pend_valid
);
  logic store;
  logic take;

  assign in_ready = !pend_valid;
  assign acc      = in_valid && in_ready;
  // a word bypasses pend only when the slot is free and nothing is queued
  assign store    = acc && (!slot_free || pend_valid);
  assign take     = slot_free && pend_valid;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pend_word  <= '0;
      pend_valid <= 1'b0;
    end else if (store) begin
      pend_word  <= in_data;
      pend_valid <= 1'b1;
    end else if (take) begin
      pend_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/conv_32a8.sv
// Serializes 32-bit words into four bytes with a one-word pending buffer.
module conv_32a8
  import conv_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);
  logic [WORD_W-1:0] cur_word;
  logic              cur_valid;
  idx_t              idx;
  logic [WORD_W-1:0] pend_word;
  logic              pend_valid;
  logic              acc;
  logic              pop;
  logic              done;
  logic              free;

  assign pop  = cur_valid && out_ready;
  assign done = pop && (idx == idx_t'(BYTES_PER_WORD-1));
  assign free = !cur_valid || done;

  word_skid u_skid (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .slot_free  (free),
    .acc        (acc),
    .pend_word  (pend_word),
    .pend_valid (pend_valid)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cur_word  <= '0;
      cur_valid <= 1'b0;
      idx       <= '0;
    end else if (free) begin
      if (pend_valid) begin
        cur_word  <= pend_word;
        cur_valid <= 1'b1;
        idx       <= '0;
      end else if (acc) begin
        cur_word  <= in_data;
        cur_valid <= 1'b1;
        idx       <= '0;
      end else begin
        cur_valid <= 1'b0;
      end
    end else if (pop) begin
      idx <= idx + idx_t'(1);
    end
  end

  assign out_data  = byte_sel(cur_word, idx, MSB_FIRST);
  assign out_valid = cur_valid;
  assign out_last  = cur_valid && (idx == idx_t'(BYTES_PER_WORD-1));
  assign busy      = cur_valid || pend_valid;
endmodule
